// File: rtl/div_frontend.sv
// div_frontend: two's-complement request front-end for the sequential sign-magnitude divider.
// Ports:
//   clk, nrst                           clock, asynchronous active-low reset
//   in_valid/in_ready, in_dividend/in_divisor
//                                       signed operand request handshake
//   out_valid/out_ready, out_quotient/out_remainder, out_dbz/out_sat/out_timeout
//                                       signed result with status flags, held until accepted
//   div_en, div_start, div_dividend/div_divisor
//                                       sign-magnitude request to the divider
//   div_done, div_quotient/div_remainder
//                                       divider completion and sign-magnitude result
module div_frontend #(
    parameter int DIV_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_dividend,
    input  logic [31:0] in_divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_quotient,
    output logic [31:0] out_remainder,
    output logic        out_dbz,
    output logic        out_sat,
    output logic        out_timeout,
    output logic        div_en,
    output logic        div_start,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic        div_done,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_remainder
);
    localparam int WW = $clog2(DIV_TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;
    state_t        state_q, state_d;
    logic [WW-1:0] wd_q, wd_d;
    logic [31:0]   dd_q, dd_d, dv_q, dv_d, q_q, q_d, r_q, r_d;
    logic          dbz_q, dbz_d, sat_q, sat_d, to_q, to_d;
    logic          a_min, b_min;
    logic [30:0]   a_abs, b_abs, a_mag, b_mag;
    logic [31:0]   cq_mag;
    // -2^31 has no 31-bit magnitude; it is clamped to 2^31-1 and flagged
    assign a_min  = in_dividend == 32'h8000_0000;
    assign b_min  = in_divisor == 32'h8000_0000;
    assign a_abs  = in_dividend[31] ? ~in_dividend[30:0] + 31'd1 : in_dividend[30:0];
    assign b_abs  = in_divisor[31] ? ~in_divisor[30:0] + 31'd1 : in_divisor[30:0];
    assign a_mag  = a_min ? 31'h7FFF_FFFF : a_abs;
    assign b_mag  = b_min ? 31'h7FFF_FFFF : b_abs;
    assign cq_mag = {1'b0, div_quotient[30:0]};
    assign in_ready      = state_q == IDLE;
    assign out_valid     = state_q == RESP;
    assign div_start     = state_q == ISSUE;
    assign div_en        = 1'b1;
    assign div_dividend  = dd_q;
    assign div_divisor   = dv_q;
    assign out_quotient  = q_q;
    assign out_remainder = r_q;
    assign out_dbz       = dbz_q;
    assign out_sat       = sat_q;
    assign out_timeout   = to_q;
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        dd_d    = dd_q;
        dv_d    = dv_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        sat_d   = sat_q;
        to_d    = to_q;
        unique case (state_q)
            IDLE: if (in_valid) begin
                dd_d  = {in_dividend[31], a_mag};
                dv_d  = {in_divisor[31], b_mag};
                sat_d = a_min | b_min;
                // divide by zero never reaches the divider
                if (in_divisor == 32'd0) begin
                    dbz_d   = 1'b1;
                    q_d     = in_dividend[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    r_d     = in_dividend;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                wd_d = wd_q + 1'b1;
                if (div_done) begin
                    state_d = CAPTURE;
                end else if (wd_q == WW'(DIV_TIMEOUT - 1)) begin
                    to_d    = 1'b1;
                    q_d     = '0;
                    r_d     = '0;
                    state_d = RESP;
                end
            end
            // divider result is valid only the cycle after div_done
            CAPTURE: begin
                q_d     = div_quotient[31] ? -cq_mag : cq_mag;
                r_d     = dd_q[31] ? -div_remainder : div_remainder;
                state_d = RESP;
            end
            RESP: if (out_ready) begin
                dbz_d   = 1'b0;
                sat_d   = 1'b0;
                to_d    = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            wd_q    <= '0;
            dd_q    <= '0;
            dv_q    <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
            sat_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            dd_q    <= dd_d;
            dv_q    <= dv_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
            sat_q   <= sat_d;
            to_q    <= to_d;
        end
    end
endmodule

// File: tb/tb_div_frontend.sv
// tb_div_frontend: vector table plus scoreboard bench for div_frontend with a behavioural divider.
module tb_div_frontend;
    logic        clk = 1'b0, nrst = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b0, div_done = 1'b0;
    logic [31:0] in_dividend = '0, in_divisor = '0;
    logic [31:0] div_quotient = '0, div_remainder = '0;
    logic        in_ready, out_valid, out_dbz, out_sat, out_timeout, div_en, div_start;
    logic [31:0] out_quotient, out_remainder, div_dividend, div_divisor;
    int          total = 0, bad = 0, starts = 0;
    always #5 clk = ~clk;
    div_frontend #(.DIV_TIMEOUT(63)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_dbz(out_dbz), .out_sat(out_sat), .out_timeout(out_timeout),
        .div_en(div_en), .div_start(div_start),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient), .div_remainder(div_remainder)
    );
    // behavioural divider: done 34 cycles after start, result valid only the following cycle
    logic        hang = 1'b0, present = 1'b0;
    int          dcnt = 0;
    logic [31:0] mq, mr, mdd;
    always @(negedge clk) begin
        div_done      = 1'b0;
        div_quotient  = present ? mq : 32'hDEAD_BEEF;
        div_remainder = present ? mr : 32'h5A5A_5A5A;
        present       = 1'b0;
        if (div_start) starts++;
        if (!nrst) begin
            dcnt = 0;
        end else if (div_start) begin
            dcnt = 34;
            mdd  = div_dividend;
            mq   = {div_dividend[31] ^ div_divisor[31], div_dividend[30:0] / div_divisor[30:0]};
            mr   = {1'b0, div_dividend[30:0] % div_divisor[30:0]};
        end else if (dcnt > 0) begin
            dcnt--;
            if (dcnt == 0 && !hang) begin
                div_done = 1'b1;
                present  = 1'b1;
            end
        end
    end
    typedef struct {
        logic [31:0] a, b, q, r, dd;
        logic        dbz, sat, to;
        int          lat, hold;
        logic        hang;
    } vec_t;
    vec_t sbq[$];
    vec_t tv[12];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", n, act, exp);
        end
    endtask
    task automatic run(input vec_t v);
        int k, s0;
        vec_t e;
        logic [31:0] q0, r0;
        @(negedge clk);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_dividend = v.a; in_divisor = v.b; hang = v.hang;
        sbq.push_back(v);
        s0 = starts;
        @(negedge clk);
        in_valid = 1'b0;
        k = 1;
        while (!out_valid && k < 200) begin
            @(negedge clk);
            k++;
        end
        e = sbq.pop_front();
        chk("latency", k, e.lat);
        chk("quotient", out_quotient, e.q);
        chk("remainder", out_remainder, e.r);
        chk("flags{dbz,sat,to}", {out_dbz, out_sat, out_timeout}, {e.dbz, e.sat, e.to});
        if (!e.dbz) chk("div_dividend", mdd, e.dd);
        q0 = out_quotient; r0 = out_remainder;
        repeat (v.hold) begin
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", out_quotient, q0);
            chk("hold_remainder", out_remainder, r0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_flags", {out_dbz, out_sat, out_timeout}, 0);
        chk("start_pulses", starts - s0, e.dbz ? 0 : 1);
    endtask
    initial begin
        int   k;
        logic seen;
        tv[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 32'h0000_0064, 0, 0, 0, 37, 10, 0};
        tv[1]  = '{32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'h8000_0064, 0, 0, 0, 37, 0, 0};
        tv[2]  = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 32'h0000_0064, 0, 0, 0, 37, 0, 0};
        tv[3]  = '{32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 32'h8000_0064, 0, 0, 0, 37, 0, 0};
        tv[4]  = '{32'd3, 32'd7, 32'd0, 32'd3, 32'h0000_0003, 0, 0, 0, 37, 0, 0};
        tv[5]  = '{32'hFFFF_FFFD, 32'd7, 32'd0, 32'hFFFF_FFFD, 32'h8000_0003, 0, 0, 0, 37, 0, 0};
        tv[6]  = '{32'd5, 32'd0, 32'h7FFF_FFFF, 32'd5, 32'd0, 1, 0, 0, 1, 0, 0};
        tv[7]  = '{32'hFFFF_FFFB, 32'd0, 32'h8000_0000, 32'hFFFF_FFFB, 32'd0, 1, 0, 0, 1, 0, 0};
        tv[8]  = '{32'h8000_0000, 32'd1, 32'h8000_0001, 32'd0, 32'hFFFF_FFFF, 0, 1, 0, 37, 0, 0};
        tv[9]  = '{32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'h8000_0007, 0, 0, 0, 37, 0, 0};
        tv[10] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 0, 1, 0, 37, 0, 0};
        tv[11] = '{32'd9, 32'd5, 32'd0, 32'd0, 32'h0000_0009, 0, 0, 1, 65, 0, 1};
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_div_start", div_start, 0);
        chk("rst_div_en", div_en, 1);
        chk("rst_q_r", {out_quotient, out_remainder} == 64'd0, 1);
        chk("rst_div_ops", {div_dividend, div_divisor} == 64'd0, 1);
        chk("rst_flags", {out_dbz, out_sat, out_timeout}, 0);
        nrst = 1'b1;
        for (int i = 0; i < 12; i++) run(tv[i]);
        // reset pulsed while the divider is busy
        @(negedge clk);
        in_valid = 1'b1; in_dividend = 32'd100; in_divisor = 32'd7; hang = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("busy_in_ready", in_ready, 0);
        nrst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_div_start", div_start, 0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 60; k++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("no_result_after_reset", seen, 0);
        run(tv[0]);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_frontend.md
# div_frontend

Request front-end for the sequential 32-bit divider in the flight-controller datapath. It accepts two's-complement operand pairs over a valid/ready handshake and converts them to the divider's sign-magnitude format. It sequences one divider transaction, then converts the result back to two's complement with truncating (C-style) semantics. Divide-by-zero and the non-representable value −2^31 are handled locally, and a watchdog guards against a hung divider.

## Interface
- DIV_TIMEOUT, 63: maximum cycles to wait for div_done after div_start; minimum 40.
- clk  in  1  system clock, all logic on rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_dividend  in  32  signed two's-complement dividend.
- in_divisor  in  32  signed two's-complement divisor.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts result.
- out_quotient  out  32  signed quotient, truncated toward zero.
- out_remainder  out  32  signed remainder, same sign as dividend (or zero).
- out_dbz  out  1  divisor was zero.
- out_sat  out  1  an operand was −2^31 and was clamped to −(2^31−1).
- out_timeout  out  1  divider did not complete within DIV_TIMEOUT.
- div_en  out  1  divider clock enable; constant 1 out of reset.
- div_start  out  1  one-cycle start pulse to divider.
- div_dividend  out  32  sign-magnitude dividend: bit31 = sign, [30:0] = magnitude.
- div_divisor  out  32  sign-magnitude divisor, same format.
- div_done  in  1  divider completion pulse.
- div_quotient  in  32  sign-magnitude quotient; valid the cycle after div_done.
- div_remainder  in  32  remainder magnitude, bit31 = 0; valid the cycle after div_done.

## Operation
- States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE: in_ready=1. On handshake, register operands and convert:
  - sign = bit31.
  - mag = |x|.
  - x = 0x80000000 maps to mag 0x7FFFFFFF with sign 1, and sets sat.
- Divisor == 0 at accept: bypass the divider and go to RESP.
  - out_quotient = 0x7FFFFFFF if dividend ≥ 0, else 0x80000000.
  - out_remainder = dividend.
  - out_dbz = 1.
- Otherwise go to ISSUE.
- ISSUE: div_start=1 for exactly one cycle, go to WAIT. Clear the watchdog.
- div_dividend/div_divisor are held constant from ISSUE until CAPTURE exits, because the divider reads the divisor through its final cycle.
- WAIT: the watchdog increments each cycle.
  - div_done → CAPTURE.
  - Watchdog reaching DIV_TIMEOUT → RESP with quotient 0, remainder 0, out_timeout=1.
- CAPTURE (one cycle): sample div_quotient and div_remainder.
  - Quotient = mag [30:0], negated if div_quotient[31]=1.
  - Remainder = magnitude, negated if the dividend sign is 1.
  - A negated zero yields 0. Go to RESP.
- RESP: out_valid=1; outputs and flags are stable. On out_ready, return to IDLE and clear the flags.
- in_ready=0 in every state except IDLE. Exactly one transaction is in flight.
- div_done seen outside WAIT is ignored.

## Timing
- Reset values:
  - state IDLE.
  - in_ready 1 (after nrst deasserts).
  - out_valid 0, div_start 0, div_en 1.
  - out_quotient/out_remainder/div_dividend/div_divisor all 0.
  - all flags 0.
  - watchdog 0.
- Reset mid-operation: immediate return to IDLE with no result produced. The divider shares nrst.
- Accept at cycle T (IDLE):
  - ISSUE is at T+1 (div_start high).
  - With the current divider, div_done arrives at T+35, CAPTURE at T+36, out_valid first high at T+37.
  - Latency is therefore 37 cycles.
- Bypass (dbz): out_valid at T+1.
- Timeout: out_valid DIV_TIMEOUT+2 cycles after accept.
- Back-to-back: with out_ready=1 at the first RESP cycle, IDLE follows and the next accept can occur one cycle after the out handshake.
- All outputs are registered. No combinational path from in_* or out_ready to any output except none.

## Test plan
- 100 / 7 → out_quotient 14, out_remainder 2, flags 0. Exactly one div_start pulse; out_valid 37 cycles after accept.
- −100 / 7 → 0xFFFFFFF2 (−14), rem 0xFFFFFFFE (−2). 100 / −7 → −14, rem 2. −100 / −7 → 14, rem −2. 3 / 7 → 0, rem 3.
- 5 / 0 → q 0x7FFFFFFF, rem 5, out_dbz=1, no div_start, out_valid at T+1. −5 / 0 → q 0x80000000, rem −5.
- 0x80000000 / 1 → q 0x80000001 (−2147483647), rem 0, out_sat=1. div_dividend = 0xFFFFFFFF.
- div_done tied low with DIV_TIMEOUT=63 → out_timeout=1, q=rem=0, out_valid 65 cycles after accept.
- out_ready held low 10 cycles in RESP → outputs stable and in_ready=0 throughout. nrst pulsed during WAIT → IDLE, out_valid never rises, the next request completes correctly.
